// File: rtl/fpa_seq_ctrl.sv
// Byte-stream sequencer for the 32-bit FP adder: gathers two operands, launches the
// adder, waits for completion under a timeout, and streams the result back out.
module fpa_seq_ctrl #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] NAN_VALUE      = 32'h7FC0_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fpa_op_a,
    output logic [31:0] fpa_op_b,
    output logic        fpa_start,
    input  logic        fpa_done,
    input  logic [31:0] fpa_result,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        start_q;
    logic [15:0] wait_q;
    logic [31:0] result_q;
    logic [1:0]  byte_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        timeout_err_q;

    logic        in_fire;
    logic        out_fire;
    logic [1:0]  byte_d;

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_LOAD);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;
    assign byte_d   = byte_q + 2'd1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= ST_LOAD;
            cnt_q         <= 3'd0;
            op_a_q        <= 32'h0;
            op_b_q        <= 32'h0;
            start_q       <= 1'b0;
            wait_q        <= 16'h0;
            result_q      <= 32'h0;
            byte_q        <= 2'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h0;
            timeout_err_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (in_fire) begin
                        // Little-endian: bytes 0..3 fill A, bytes 4..7 fill B.
                        if (!cnt_q[2]) begin
                            op_a_q[{cnt_q[1:0], 3'b000} +: 8] <= in_data;
                        end else begin
                            op_b_q[{cnt_q[1:0], 3'b000} +: 8] <= in_data;
                        end
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q <= ST_START;
                            start_q <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    wait_q        <= 16'h0;
                    timeout_err_q <= 1'b0;
                    state_q       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion arriving on the expiry cycle still takes priority.
                    if (fpa_done) begin
                        result_q    <= fpa_result;
                        out_data_q  <= fpa_result[7:0];
                        out_valid_q <= 1'b1;
                        byte_q      <= 2'd0;
                        state_q     <= ST_SEND;
                    end else if (wait_q == WAIT_LAST) begin
                        result_q      <= NAN_VALUE;
                        out_data_q    <= NAN_VALUE[7:0];
                        out_valid_q   <= 1'b1;
                        byte_q        <= 2'd0;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_SEND;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                ST_SEND: begin
                    if (out_fire) begin
                        if (byte_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            byte_q      <= 2'd0;
                            state_q     <= ST_LOAD;
                        end else begin
                            byte_q     <= byte_d;
                            out_data_q <= result_q[{byte_d, 3'b000} +: 8];
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign fpa_op_a    = op_a_q;
    assign fpa_op_b    = op_b_q;
    assign fpa_start   = start_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fpa_seq_ctrl.sv
// Directed bench for fpa_seq_ctrl; the bench itself plays the adder and the result consumer.
module tb_fpa_seq_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fpa_op_a;
    logic [31:0] fpa_op_b;
    logic        fpa_start;
    logic        fpa_done;
    logic [31:0] fpa_result;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    fpa_seq_ctrl #(
        .TIMEOUT_CYCLES(8),
        .NAN_VALUE     (32'h7FC0_0000)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fpa_op_a   (fpa_op_a),
        .fpa_op_b   (fpa_op_b),
        .fpa_start  (fpa_start),
        .fpa_done   (fpa_done),
        .fpa_result (fpa_result),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // Streams A then B little-endian; returns on the negedge of the cycle after byte 7.
    task automatic load_operands(input logic [31:0] a, input logic [31:0] b, input bit gaps);
        logic [63:0] stream;
        stream = {b, a};
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                @(negedge wb_clk_i);
                in_valid = 1'b0;
                in_data  = 8'hEE;
            end
            @(negedge wb_clk_i);
            in_data  = stream[8*i +: 8];
            in_valid = 1'b1;
        end
        @(negedge wb_clk_i);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Steps d cycles through WAIT while offering junk input; optionally pulses done on the last.
    task automatic run_wait(input int d, input bit give_done, input logic [31:0] res,
                            output int starts, output int ready_hi, output int valid_hi);
        starts = 0; ready_hi = 0; valid_hi = 0;
        for (int k = 0; k < d; k++) begin
            @(negedge wb_clk_i);
            if (fpa_start === 1'b1) starts++;
            if (in_ready === 1'b1) ready_hi++;
            if (out_valid === 1'b1) valid_hi++;
            in_valid = 1'b1;
            in_data  = 8'hA5;
        end
        if (give_done) begin
            fpa_done   = 1'b1;
            fpa_result = res;
            @(negedge wb_clk_i);
            fpa_done   = 1'b0;
            fpa_result = 32'hDEAD_BEEF;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Collects four result bytes, stalling each one for 'stall' cycles before accepting it.
    task automatic recv_word(input int stall, output logic [31:0] word,
                             output int held_bad, output int xfers);
        logic [7:0] b;
        int wait_cyc;
        word = 32'h0; held_bad = 0; xfers = 0;
        for (int j = 0; j < 4; j++) begin
            wait_cyc = 0;
            while (out_valid !== 1'b1 && wait_cyc < 40) begin
                @(negedge wb_clk_i);
                wait_cyc++;
            end
            if (out_valid !== 1'b1) break;
            b = out_data;
            for (int s = 0; s < stall; s++) begin
                @(negedge wb_clk_i);
                if (out_data !== b || out_valid !== 1'b1) held_bad++;
            end
            out_ready = 1'b1;
            @(negedge wb_clk_i);
            out_ready = 1'b0;
            word[8*j +: 8] = b;
            xfers++;
        end
    endtask

    task automatic test_reset;
        wb_rst_ni = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (fpa_start !== 1'b0) begin errors++; $display("FAIL reset_fpa_start: got %b expected 0", fpa_start); end
        checks++; if (fpa_op_a !== 32'h0 || fpa_op_b !== 32'h0) begin errors++; $display("FAIL reset_ops: got a=%h b=%h expected 0/0", fpa_op_a, fpa_op_b); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        $display("reset: released, in_ready=%b busy=%b", in_ready, busy);
    endtask

    task automatic test_basic_add;
        int starts, rdy, vld, held, xf;
        logic [31:0] w;
        load_operands(32'h3F80_0000, 32'h4000_0000, 1'b0);
        checks++; if (fpa_start !== 1'b1) begin errors++; $display("FAIL basic_start: got %b expected 1", fpa_start); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_start: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        run_wait(5, 1'b1, 32'h4040_0000, starts, rdy, vld);
        checks++; if (starts != 0) begin errors++; $display("FAIL basic_single_start: got %0d extra pulses expected 0", starts); end
        checks++; if (rdy != 0 || vld != 0) begin errors++; $display("FAIL basic_wait_flags: got in_ready_cycles=%0d out_valid_cycles=%0d expected 0/0", rdy, vld); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL basic_latency: got valid=%b data=%h expected 1/00", out_valid, out_data); end
        checks++; if (fpa_op_a !== 32'h3F80_0000 || fpa_op_b !== 32'h4000_0000) begin errors++; $display("FAIL basic_ops: got a=%h b=%h expected 3f800000/40000000", fpa_op_a, fpa_op_b); end
        recv_word(0, w, held, xf);
        checks++; if (w !== 32'h4040_0000 || xf != 4) begin errors++; $display("FAIL basic_result: got %h (%0d bytes) expected 40400000 (4 bytes)", w, xf); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
        $display("basic_add: a=3f800000 b=40000000 result=%h", w);
    endtask

    task automatic test_input_gaps;
        int starts, rdy, vld, held, xf;
        logic [31:0] w;
        load_operands(32'h3F80_0000, 32'h4000_0000, 1'b1);
        checks++; if (fpa_start !== 1'b1) begin errors++; $display("FAIL gaps_start: got %b expected 1", fpa_start); end
        checks++; if (fpa_op_a !== 32'h3F80_0000 || fpa_op_b !== 32'h4000_0000) begin errors++; $display("FAIL gaps_ops: got a=%h b=%h expected 3f800000/40000000", fpa_op_a, fpa_op_b); end
        run_wait(3, 1'b1, 32'h4040_0000, starts, rdy, vld);
        recv_word(0, w, held, xf);
        checks++; if (w !== 32'h4040_0000 || xf != 4) begin errors++; $display("FAIL gaps_result: got %h (%0d bytes) expected 40400000 (4 bytes)", w, xf); end
        $display("input_gaps: a=%h b=%h result=%h", fpa_op_a, fpa_op_b, w);
    endtask

    task automatic test_backpressure;
        int starts, rdy, vld, held, xf;
        logic [31:0] w;
        load_operands(32'hBFC0_0000, 32'h4050_0000, 1'b0);
        run_wait(2, 1'b1, 32'h3FE0_0000, starts, rdy, vld);
        recv_word(3, w, held, xf);
        checks++; if (held != 0) begin errors++; $display("FAIL bp_hold: got %0d stall cycles with changed data expected 0", held); end
        checks++; if (w !== 32'h3FE0_0000 || xf != 4) begin errors++; $display("FAIL bp_result: got %h (%0d bytes) expected 3fe00000 (4 bytes)", w, xf); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        $display("backpressure: a=bfc00000 b=40500000 result=%h", w);
    endtask

    task automatic test_timeout;
        int starts, rdy, vld, held, xf;
        logic [31:0] w;
        load_operands(32'h3F80_0000, 32'h4000_0000, 1'b0);
        run_wait(8, 1'b0, 32'h0, starts, rdy, vld);
        checks++; if (vld != 0 || busy !== 1'b1) begin errors++; $display("FAIL to_wait_len: got out_valid_cycles=%0d busy=%b expected 0/1", vld, busy); end
        @(negedge wb_clk_i);
        checks++; if (out_valid !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_expire: got valid=%b timeout_err=%b expected 1/1", out_valid, timeout_err); end
        recv_word(0, w, held, xf);
        checks++; if (w !== 32'h7FC0_0000 || xf != 4) begin errors++; $display("FAIL to_result: got %h (%0d bytes) expected 7fc00000 (4 bytes)", w, xf); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
        $display("timeout: a=3f800000 b=40000000 result=%h timeout_err=%b", w, timeout_err);
    endtask

    task automatic test_done_at_expiry;
        int starts, rdy, vld, held, xf;
        logic [31:0] w;
        load_operands(32'h4000_0000, 32'h4000_0000, 1'b0);
        run_wait(1, 1'b0, 32'h0, starts, rdy, vld);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL expiry_clear: got %b expected 0", timeout_err); end
        run_wait(7, 1'b1, 32'h4080_0000, starts, rdy, vld);
        checks++; if (out_valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL expiry_done_wins: got valid=%b timeout_err=%b expected 1/0", out_valid, timeout_err); end
        recv_word(0, w, held, xf);
        checks++; if (w !== 32'h4080_0000 || xf != 4) begin errors++; $display("FAIL expiry_result: got %h (%0d bytes) expected 40800000 (4 bytes)", w, xf); end
        $display("done_at_expiry: a=40000000 b=40000000 result=%h timeout_err=%b", w, timeout_err);
    endtask

    task automatic test_reset_mid_op;
        int starts, rdy, vld, held, xf;
        logic [31:0] w;
        load_operands(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        run_wait(4, 1'b1, 32'h4000_0000, starts, rdy, vld);
        out_ready = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        out_ready = 1'b0;
        #2 wb_rst_ni = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (fpa_op_a !== 32'h0 || fpa_op_b !== 32'h0) begin errors++; $display("FAIL midrst_ops: got a=%h b=%h expected 0/0", fpa_op_a, fpa_op_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        fpa_done   = 1'b1;
        fpa_result = 32'hFFFF_FFFF;
        @(negedge wb_clk_i);
        fpa_done   = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stray_done: got busy=%b valid=%b expected 0/0", busy, out_valid); end
        load_operands(32'h4040_0000, 32'h3F80_0000, 1'b0);
        checks++; if (fpa_start !== 1'b1 || fpa_op_a !== 32'h4040_0000 || fpa_op_b !== 32'h3F80_0000) begin errors++; $display("FAIL midrst_reload: got start=%b a=%h b=%h expected 1/40400000/3f800000", fpa_start, fpa_op_a, fpa_op_b); end
        run_wait(2, 1'b1, 32'h4080_0000, starts, rdy, vld);
        recv_word(0, w, held, xf);
        checks++; if (w !== 32'h4080_0000 || xf != 4) begin errors++; $display("FAIL midrst_result: got %h (%0d bytes) expected 40800000 (4 bytes)", w, xf); end
        $display("reset_mid_op: reload a=40400000 b=3f800000 result=%h", w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst_ni  = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        fpa_done   = 1'b0;
        fpa_result = 32'h0;
        test_reset();
        test_basic_add();
        test_input_gaps();
        test_backpressure();
        test_timeout();
        test_done_at_expiry();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpa_seq_ctrl.md
Name: fpa_seq_ctrl

Overview:
- Sequencer that feeds the 32-bit floating-point adder datapath through the narrow 8-bit user I/O path.
- Collects two operands as a byte stream and launches the adder with a one-cycle start pulse, then waits for completion with a timeout.
- Returns the 32-bit result as a byte stream with valid/ready flow control.
- Sits in the user project between the I/O pad mapping (io_in[7:0] data, io_in/io_out[37:30] handshake and result) and the adder core.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent in WAIT before the operation is aborted; legal range 2..65535.
- NAN_VALUE, 32'h7FC0_0000, result word returned on timeout.

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts a byte; a transfer occurs when in_valid & in_ready.
- out_data  out  8  result byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the byte; a transfer occurs when out_valid & out_ready.
- fpa_op_a  out  32  adder operand A.
- fpa_op_b  out  32  adder operand B.
- fpa_start  out  1  one-cycle launch pulse.
- fpa_done  in  1  adder result valid, single-cycle pulse.
- fpa_result  in  32  adder result, valid when fpa_done = 1.
- busy  out  1  high in every state except LOAD.
- timeout_err  out  1  sticky error flag: the last operation timed out.

Behaviour:
- Reset (wb_rst_ni = 0, asynchronous, any state, including mid-operation): state = LOAD, byte counter = 0, fpa_op_a = fpa_op_b = 0, fpa_start = 0, out_valid = 0, out_data = 0, timeout_err = 0, busy = 0, wait counter = 0. in_ready = 1 once reset is released.
- All outputs are registered except in_ready (= state==LOAD) and busy (= state!=LOAD).
- LOAD state:
  - Each accepted byte is written at byte index cnt (0..7), little-endian.
  - Bytes 0..3 go to fpa_op_a[8k+7:8k]; bytes 4..7 go to fpa_op_b[8(k-4)+7:8(k-4)].
  - cnt increments per accepted byte. Cycles with in_valid = 0 do not advance cnt.
  - When byte 7 is accepted at edge N: cnt wraps to 0, next state = START.
- START state:
  - Lasts exactly one cycle with fpa_start = 1.
  - Sets wait counter = 0 and clears timeout_err.
  - Next state = WAIT.
- WAIT state:
  - fpa_op_a and fpa_op_b are held stable from START until WAIT is exited.
  - If fpa_done = 1: capture fpa_result into the result register, next state = SEND.
  - Else if wait counter == TIMEOUT_CYCLES-1: load NAN_VALUE into the result register, set timeout_err = 1, next state = SEND.
  - Else: increment wait counter.
  - If fpa_done and the timeout expiry occur in the same cycle, fpa_done wins: the real result is returned and timeout_err stays 0.
- fpa_done outside WAIT is ignored.
- SEND state:
  - out_valid = 1. out_data = result byte j (j = 0..3, LS byte first).
  - out_data and out_valid stay stable while out_ready = 0.
  - On each accepted byte, j increments. After byte 3 is accepted: out_valid = 0, j = 0, next state = LOAD.
- Latency: last operand byte accepted at edge N -> fpa_start high in cycle N+1. fpa_done sampled at edge M -> out_valid = 1 with byte 0 in cycle M+1.
- in_ready is 0 in START, WAIT and SEND; input bytes offered in those states are not consumed.

Test Plan:
- Basic add:
  - Stimulus: send bytes 00 00 80 3F 00 00 00 40 (1.0, 2.0).
  - Required: fpa_op_a = 3F800000, fpa_op_b = 40000000, single fpa_start pulse; model returns 40400000 after 5 cycles; out bytes 00 00 40 40; then in_ready = 1 and busy = 0.
- Input gaps:
  - Stimulus: in_valid toggled 1/0 across the 8 bytes.
  - Required: operands identical to the basic case; fpa_start exactly one cycle after the 8th accepted byte.
- Output backpressure:
  - Stimulus: out_ready = 0 for 3 cycles on each byte.
  - Required: out_data held constant during the stall; each byte delivered exactly once; exactly 4 transfers.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8, fpa_done never asserted.
  - Required: after 8 WAIT cycles, out bytes 00 00 C0 7F and timeout_err = 1; the next fpa_start clears timeout_err.
- Done at expiry:
  - Stimulus: fpa_done pulses in the cycle where wait counter = TIMEOUT_CYCLES-1.
  - Required: fpa_result is returned and timeout_err = 0.
- Reset mid-operation:
  - Stimulus: assert wb_rst_ni = 0 asynchronously in SEND after byte 1.
  - Required: out_valid = 0 immediately; fpa_op_a and fpa_op_b read 0; after release, a fresh 8-byte load works and a stray fpa_done during LOAD has no effect.
